// File: rtl/st_video_fetch_if.sv
// Memory read port and shifter load port of the video fetch sequencer.
// master = fetch sequencer side, slave = memory/shifter side.
interface st_video_fetch_if #(
  parameter int ADDR_W = 21
);
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_ack;
  logic [15:0]       mem_data;
  logic              load;
  logic [15:0]       data;

  modport master (
    output mem_req, mem_addr, load, data,
    input  mem_ack, mem_data
  );

  modport slave (
    input  mem_req, mem_addr, load, data,
    output mem_ack, mem_data
  );
endinterface

// File: rtl/st_video_fetch.sv
// Video fetch sequencer: one memory word per LOAD_PERIOD slot while de is high, handed to the shifter on a LOAD_LOW-cycle load pulse.
// Request issues one cycle after slot start; a word not acked before load start is replaced by zero and flagged as underrun.
module st_video_fetch #(
  parameter int ADDR_W      = 21,
  parameter int LOAD_PERIOD = 16,
  parameter int LOAD_LOW    = 4
) (
  input  logic              CLOCK_32,
  input  logic              reset_n,
  input  logic              de,
  input  logic              vsync,
  input  logic [ADDR_W-1:0] base_addr,
  output logic              underrun,
  st_video_fetch_if.master  bus
);
  localparam int PW = $clog2(LOAD_PERIOD);
  localparam logic [PW-1:0] WIN_START = PW'(LOAD_PERIOD - LOAD_LOW);

  typedef enum logic [1:0] {IDLE, REQ, HOLD} state_t;

  state_t            state;
  logic [PW-1:0]     phase;
  logic [PW-1:0]     phase_nxt;
  logic [ADDR_W-1:0] addr;
  logic [15:0]       word_q;
  logic [15:0]       slot_word;

  // Once a pulse has started it runs to the wrap even if de drops.
  always_comb begin
    phase_nxt = '0;
    if (de || (phase != '0 && phase >= WIN_START))
      phase_nxt = phase + PW'(1);
  end

  // The word handed over at load start; an ack on that same edge wins over the deadline.
  always_comb begin
    slot_word = word_q;
    if (state == REQ)
      slot_word = bus.mem_ack ? bus.mem_data : 16'h0000;
  end

  always_ff @(posedge CLOCK_32) begin
    if (!reset_n) begin
      state        <= IDLE;
      phase        <= '0;
      addr         <= '0;
      word_q       <= '0;
      bus.mem_req  <= 1'b0;
      bus.mem_addr <= '0;
      bus.load     <= 1'b1;
      bus.data     <= '0;
      underrun     <= 1'b0;
    end else begin
      phase    <= phase_nxt;
      bus.load <= !(phase_nxt >= WIN_START);
      if (phase_nxt == WIN_START)
        bus.data <= slot_word;

      case (state)
        IDLE: begin
          if (de && phase == '0) begin
            state        <= REQ;
            bus.mem_req  <= 1'b1;
            bus.mem_addr <= addr;
          end
        end
        REQ: begin
          if (bus.mem_ack) begin
            word_q      <= bus.mem_data;
            addr        <= addr + ADDR_W'(1);
            bus.mem_req <= 1'b0;
            state       <= de ? HOLD : IDLE;
          end else if (de && phase_nxt == WIN_START) begin
            // Missed deadline: still advance so the rest of the line stays aligned.
            word_q      <= 16'h0000;
            addr        <= addr + ADDR_W'(1);
            bus.mem_req <= 1'b0;
            underrun    <= 1'b1;
            state       <= HOLD;
          end
        end
        HOLD: begin
          if (phase_nxt == '0)
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase

      if (vsync) begin
        addr     <= base_addr;
        underrun <= 1'b0;
      end
    end
  end
endmodule
